clk_sel_ctrl: RTL and testbench

Control stage directly upstream of the glitch-free clock switch: it owns the `sel` line the switch consumes. Software or a power manager issues switch requests over a valid/ready handshake. The block checks that the target clock is reported alive and drives `sel`. It then waits a settle window, long enough for the switch's cross-domain hand-off to complete, before reporting `done`. A minimum dwell time prevents back-to-back toggling.

---
 rtl/clk_sel_pkg.sv | 13 +
 rtl/sync2.sv | 22 ++
 rtl/clk_sel_ctrl.sv | 110 +++++++++++
 tb/tb_clk_sel_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clk_sel_pkg.sv
// rtl/clk_sel_pkg.sv - shared types and constants for the clock select controller
package clk_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for an asynchronous status bit, resets to 0
module sync2 (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - request/settle/dwell controller that owns the clock switch select line
module clk_sel_ctrl
  import clk_sel_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_CYC  = 64,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic clk_ok_A,
  input  logic clk_ok_B,
  output logic sel,
  output logic busy,
  output logic done,
  output logic err,
  output logic clk_lost
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ok_a_s, ok_b_s;
  logic              accept;
  logic              target_ok;

  sync2 u_sync_a (.clk(clk), .rstn(rstn), .d(clk_ok_A), .q(ok_a_s));
  sync2 u_sync_b (.clk(clk), .rstn(rstn), .d(clk_ok_B), .q(ok_b_s));

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign target_ok = (req_sel == SEL_B) ? ok_b_s : ok_a_s;

  // State, shared down-counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= SEL_A;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state: classify accepted requests, then count out settle and dwell windows.
  // The counter is only loaded on state entry and a zero count always leaves the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else if (!target_ok) begin
            err_d = 1'b1;
          end else begin
            sel_d   = req_sel;
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          cnt_d   = DWELL_LD;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign sel      = sel_q;
  assign done     = done_q;
  assign err      = err_q;
  assign busy     = (state_q == SETTLE) || (state_q == DWELL);
  assign clk_lost = sel_q ? ~ok_b_s : ~ok_a_s;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb/tb_clk_sel_ctrl.sv - scoreboard bench for clk_sel_ctrl
module tb_clk_sel_ctrl;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn, req_valid, req_sel, clk_ok_A, clk_ok_B;
  logic req_ready, sel, busy, done, err, clk_lost;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb[$];
  int   e0, e1;

  clk_sel_ctrl #(.SETTLE_CYC(16), .DWELL_CYC(64), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_sel(req_sel),
    .req_ready(req_ready), .clk_ok_A(clk_ok_A), .clk_ok_B(clk_ok_B),
    .sel(sel), .busy(busy), .done(done), .err(err), .clk_lost(clk_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic s, output int edge_cyc);
    chk("rdy_pre", req_ready, 1);
    req_valid = 1'b1;
    req_sel   = s;
    tick();
    edge_cyc  = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", req_ready, 1);
  endtask

  // Output monitor: every done/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (done || err) begin
      if (sb.size() == 0) begin
        chk("unexp_evt", {30'd0, done, err}, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("evt_kind", {30'd0, done, err}, {30'd0, e.kind});
        chk("evt_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_sel = 1'b0;
    clk_ok_A = 1'b1; clk_ok_B = 1'b1;

    // reset state
    repeat (3) tick();
    chk("rst_sel", sel, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lost", clk_lost, 1);
    rstn = 1'b1;
    tick();
    chk("lost_e1", clk_lost, 1);
    tick();
    chk("lost_e2", clk_lost, 0);

    // switch to B, with a held request arriving during dwell
    do_req(1'b1, e0);
    sb.push_back('{EV_DONE, e0 + 16});
    chk("sw_sel", sel, 1);
    chk("sw_busy", busy, 1);
    chk("sw_ready", req_ready, 0);
    repeat (19) tick();
    req_valid = 1'b1;
    req_sel   = 1'b0;
    repeat (60) tick();
    chk("sw_busy79", busy, 1);
    chk("sw_sel79", sel, 1);
    tick();
    chk("sw_busy80", busy, 0);
    chk("sw_ready80", req_ready, 1);
    chk("held_not_acc", sel, 1);
    tick();
    e1 = cyc;
    sb.push_back('{EV_DONE, e1 + 16});
    req_valid = 1'b0;
    chk("held_acc_sel", sel, 0);
    chk("held_acc_busy", busy, 1);
    wait_idle();

    // no-op requests, back to back
    req_valid = 1'b1;
    req_sel   = 1'b0;
    tick();
    e0 = cyc;
    sb.push_back('{EV_DONE, e0});
    chk("noop_busy", busy, 0);
    chk("noop_ready", req_ready, 1);
    chk("noop_sel", sel, 0);
    tick();
    sb.push_back('{EV_DONE, e0 + 1});
    req_valid = 1'b0;
    chk("noop2_sel", sel, 0);
    chk("noop2_busy", busy, 0);
    repeat (2) tick();

    // target not OK -> err
    clk_ok_B = 1'b0;
    repeat (3) tick();
    chk("errsc_lost", clk_lost, 0);
    do_req(1'b1, e0);
    sb.push_back('{EV_ERR, e0});
    chk("err_sel", sel, 0);
    chk("err_busy", busy, 0);
    chk("err_ready", req_ready, 1);
    tick();
    clk_ok_B = 1'b1;
    repeat (3) tick();

    // target drops during settle: no abort, clk_lost after two edges
    do_req(1'b1, e0);
    sb.push_back('{EV_DONE, e0 + 16});
    repeat (3) tick();
    clk_ok_B = 1'b0;
    tick();
    chk("drop_lost1", clk_lost, 0);
    tick();
    chk("drop_lost2", clk_lost, 1);
    chk("drop_busy", busy, 1);
    wait_idle();
    chk("drop_sel", sel, 1);
    clk_ok_B = 1'b1;
    repeat (2) tick();
    chk("restore_lost", clk_lost, 0);

    // back to A, then to B and reset mid-settle
    do_req(1'b0, e0);
    sb.push_back('{EV_DONE, e0 + 16});
    wait_idle();
    chk("back_a_sel", sel, 0);
    do_req(1'b1, e0);
    chk("pre_rst_sel", sel, 1);
    repeat (5) tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_done", done, 0);
    repeat (2) tick();
    rstn = 1'b1;
    repeat (40) tick();
    chk("post_rst_sel", sel, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
